// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: merges load-use, mispredict,
// IMEM readiness and DMEM handshake into per-stage controls, with a DMEM wait/timeout FSM.
module pipeline_hazard_ctrl #(
  parameter int unsigned DMEM_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_hazard,
  input  logic             branch_mispredict_ex,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             bubble_mem,
  output logic             dmem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WAIT_W = $clog2(DMEM_TIMEOUT + 1) + 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(DMEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_FAULT    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              run_rules;
  logic              mispredict_taken;
  logic              any_stall;

  // Next-state and zero-latency control decode.
  always_comb begin
    state_d          = state_q;
    wait_d           = wait_q;
    timeout_d        = timeout_q;
    run_rules        = 1'b0;
    mispredict_taken = 1'b0;
    stall_if         = 1'b0;
    stall_id         = 1'b0;
    stall_ex         = 1'b0;
    stall_mem        = 1'b0;
    flush_id         = 1'b0;
    flush_ex         = 1'b0;
    bubble_mem       = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (dmem_req && !dmem_ack) begin
          {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          run_rules = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ack) begin
          {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
          wait_d = wait_q + WAIT_W'(1);
          if (wait_q == TIMEOUT_VAL) begin
            state_d   = ST_FAULT;
            timeout_d = 1'b1;
          end else begin
            state_d = ST_MEM_WAIT;
          end
        end else begin
          run_rules = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_FAULT: begin
        {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
        timeout_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // A mispredict alongside load-use is dropped: its EX operand is stale and it re-presents.
    if (run_rules) begin
      if (load_use_hazard) begin
        {stall_if, stall_id, stall_ex} = 3'b111;
        bubble_mem = 1'b1;
      end else if (branch_mispredict_ex) begin
        flush_id         = 1'b1;
        flush_ex         = 1'b1;
        mispredict_taken = 1'b1;
      end else if (!imem_ready) begin
        stall_if = 1'b1;
        flush_id = 1'b1;
      end else begin
        flush_id = 1'b0;
      end
    end else begin
      mispredict_taken = 1'b0;
    end

    if (rst) begin
      {stall_if, stall_id, stall_ex, stall_mem} = 4'b0000;
      {flush_id, flush_ex, bubble_mem}          = 3'b000;
      mispredict_taken                          = 1'b0;
    end else begin
      state_d = state_d;
    end

    any_stall = stall_if | stall_id | stall_ex | stall_mem;

    if (any_stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end

    if (mispredict_taken && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State, wait counter, sticky fault flag and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign dmem_timeout = timeout_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl with a short timeout and 3-bit counters
// so that FAULT entry and counter saturation are both reachable.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_use_hazard, branch_mispredict_ex, imem_ready, dmem_req, dmem_ack;
  logic       stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_mem;
  logic       dmem_timeout;
  logic [2:0] stall_cycles, flush_count;

  // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_mem}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_ALL  = 7'b1111000;
  localparam logic [6:0] C_LU   = 7'b1110001;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_IM   = 7'b1000100;

  int         checks = 0;
  int         errors = 0;
  logic [6:0] exp_q[$];
  logic [2:0] m_stall = 3'd0;
  logic [2:0] m_flush = 3'd0;

  pipeline_hazard_ctrl #(.DMEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .load_use_hazard     (load_use_hazard),
    .branch_mispredict_ex(branch_mispredict_ex),
    .imem_ready          (imem_ready),
    .dmem_req            (dmem_req),
    .dmem_ack            (dmem_ack),
    .stall_if            (stall_if),
    .stall_id            (stall_id),
    .stall_ex            (stall_ex),
    .stall_mem           (stall_mem),
    .flush_id            (flush_id),
    .flush_ex            (flush_ex),
    .bubble_mem          (bubble_mem),
    .dmem_timeout        (dmem_timeout),
    .stall_cycles        (stall_cycles),
    .flush_count         (flush_count)
  );

  always #5 clk = ~clk;

  // Drive one cycle, compare controls mid-cycle against the queued expectation, then advance.
  task automatic step(input logic lu, input logic br, input logic im, input logic req,
                      input logic ack, input logic [6:0] exp, input string tag);
    logic [6:0] got, want;
    load_use_hazard      = lu;
    branch_mispredict_ex = br;
    imem_ready           = im;
    dmem_req             = req;
    dmem_ack             = ack;
    exp_q.push_back(exp);
    #4;
    got  = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_mem};
    want = exp_q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: controls got %b expected %b", tag, got, want);
    end
    if (!rst) begin
      if ((want[6:3] != 4'b0000) && (m_stall != 3'd7)) m_stall = m_stall + 3'd1;
      if ((want == C_BR) && (m_flush != 3'd7)) m_flush = m_flush + 3'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input logic exp_to, input string tag);
    checks++;
    assert (stall_cycles === m_stall) else begin
      errors++;
      $error("FAIL %s stall_cycles: got %0d expected %0d", tag, stall_cycles, m_stall);
    end
    checks++;
    assert (flush_count === m_flush) else begin
      errors++;
      $error("FAIL %s flush_count: got %0d expected %0d", tag, flush_count, m_flush);
    end
    checks++;
    assert (dmem_timeout === exp_to) else begin
      errors++;
      $error("FAIL %s dmem_timeout: got %b expected %b", tag, dmem_timeout, exp_to);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, C_NONE, "reset_c0");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, C_NONE, "reset_c1");
    rst     = 1'b0;
    m_stall = 3'd0;
    m_flush = 3'd0;
  endtask

  initial begin
    // Reset with all inputs high, then idle in RUN.
    do_reset();
    check_regs(1'b0, "after_reset");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, "idle");

    // Single load-use bubble.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_LU, "load_use");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, "after_load_use");
    check_regs(1'b0, "load_use");

    // DMEM wait with ack on the 4th cycle; hazards ignored while waiting.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_ALL, "dmem_req");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, C_ALL, "wait_ignores");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_ALL, "wait_3");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, C_NONE, "ack_cycle");
    check_regs(1'b0, "dmem_wait");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, C_LU, "req_ack_same_lu");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_ALL, "dmem_req2");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, C_BR, "ack_with_mispredict");
    check_regs(1'b0, "ack_branch");

    // Load-use masks a simultaneous mispredict; mispredict alone flushes.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, C_LU, "lu_over_br");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_BR, "mispredict");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_IM, "imem_not_ready");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_BR, "redirect_over_imem");
    check_regs(1'b0, "branch_imem");

    // Counter saturation at 7 on fresh counters.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_LU, "sat_lu");
    check_regs(1'b0, "pre_sat");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_LU, "sat_lu");
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_BR, "sat_br");
    check_regs(1'b0, "saturated");

    // Timeout: RUN entry plus four MEM_WAIT cycles, then FAULT is sticky.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_ALL, "to_enter");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_ALL, "to_wait");
    check_regs(1'b0, "before_timeout");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_ALL, "to_last_wait");
    check_regs(1'b1, "timeout_set");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, C_ALL, "fault_ignores_ack");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_ALL, "fault_holds");
    check_regs(1'b1, "fault_sticky");
    do_reset();
    check_regs(1'b0, "fault_cleared");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, "run_after_fault");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
